// File: rtl/sc_mul_lfsr_mc.sv
// rtl/sc_mul_lfsr_mc.sv - multi-channel unipolar stochastic multiplier over two shared LFSRs
//
// Each lane compares its captured operands against two shared Galois LFSRs.
// It ANDs the two resulting stochastic bits and counts the ones over a
// window of P*P cycles, where P = 2^WIDTH-1.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         launch request, honoured only while busy=0
//   mode          0 = rotate B LFSR, 1 = exhaustive (nested) B LFSR
//   seed_a/b      LFSR seeds, a zero seed is replaced by 1
//   a, b          packed lane operands, lane i at [i*WIDTH +: WIDTH]
//   busy          high for the whole compare window
//   done          one-cycle pulse after the last compare cycle
//   result        packed lane ones counts, lane i at [i*2*WIDTH +: 2*WIDTH]

module sc_mul_lfsr_mc #(
    parameter int               WIDTH  = 8,
    parameter int               NUM_CH = 4,
    parameter logic [WIDTH-1:0] TAPS   = 8'hB8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        mode,
    input  logic [WIDTH-1:0]            seed_a,
    input  logic [WIDTH-1:0]            seed_b,
    input  logic [NUM_CH*WIDTH-1:0]     a,
    input  logic [NUM_CH*WIDTH-1:0]     b,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_CH*2*WIDTH-1:0]   result
);

    localparam int               AW      = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    // Last phase index P-1 = 2^W-2.
    localparam logic [WIDTH-1:0] PH_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      mode_q, mode_d;
    logic [WIDTH-1:0]          lfsr_a_q, lfsr_a_d;
    logic [WIDTH-1:0]          lfsr_b_q, lfsr_b_d;
    logic [WIDTH-1:0]          seed_a_q, seed_a_d;
    logic [WIDTH-1:0]          inner_q, inner_d;
    logic [WIDTH-1:0]          outer_q, outer_d;
    logic [NUM_CH*WIDTH-1:0]   a_q, a_d;
    logic [NUM_CH*WIDTH-1:0]   b_q, b_d;
    logic [AW-1:0]             acc_q [NUM_CH];
    logic [AW-1:0]             acc_d [NUM_CH];
    logic [NUM_CH*AW-1:0]      result_q, result_d;

    logic [WIDTH-1:0]          seed_a_eff;
    logic [WIDTH-1:0]          seed_b_eff;
    logic [WIDTH-1:0]          lfsr_a_nxt;
    logic                      wrap;
    logic                      last_cyc;
    logic                      b_step;
    logic [NUM_CH-1:0]         hit;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    always_comb begin
        seed_a_eff = (seed_a == '0) ? ONE_W : seed_a;
        seed_b_eff = (seed_b == '0) ? ONE_W : seed_b;
        lfsr_a_nxt = lfsr_step(lfsr_a_q);
        // A returns to its seed once per period, so this marks the
        // last cycle of every inner period.
        wrap       = (lfsr_a_nxt == seed_a_q);
        last_cyc   = (inner_q == PH_LAST) && (outer_q == PH_LAST);
        // Exhaustive: B advances once per A period (nested loops).
        // Rotate: B advances every cycle except on a wrap, so the A/B
        // alignment shifts by one in each period.
        b_step     = mode_q ? wrap : !wrap;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = (a_q[i*WIDTH +: WIDTH] > lfsr_a_q) &&
                     (b_q[i*WIDTH +: WIDTH] > lfsr_b_q);
        end
    end

    always_comb begin
        busy_d   = busy_q;
        done_d   = 1'b0;
        mode_d   = mode_q;
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        seed_a_d = seed_a_q;
        inner_d  = inner_q;
        outer_d  = outer_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
        end

        if (!busy_q) begin
            if (start) begin
                busy_d   = 1'b1;
                mode_d   = mode;
                a_d      = a;
                b_d      = b;
                seed_a_d = seed_a_eff;
                lfsr_a_d = seed_a_eff;
                lfsr_b_d = seed_b_eff;
                inner_d  = '0;
                outer_d  = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    acc_d[i] = '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_d[i] = acc_q[i] + {{(AW-1){1'b0}}, hit[i]};
            end
            lfsr_a_d = lfsr_a_nxt;
            if (b_step) begin
                lfsr_b_d = lfsr_step(lfsr_b_q);
            end
            if (inner_q == PH_LAST) begin
                inner_d = '0;
                outer_d = outer_q + ONE_W;
            end else begin
                inner_d = inner_q + ONE_W;
            end
            if (last_cyc) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                // The final compare bit is already folded into acc_d.
                for (int i = 0; i < NUM_CH; i++) begin
                    result_d[i*AW +: AW] = acc_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= 1'b0;
            lfsr_a_q <= ONE_W;
            lfsr_b_q <= ONE_W;
            seed_a_q <= ONE_W;
            inner_q  <= '0;
            outer_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            seed_a_q <= seed_a_d;
            inner_q  <= inner_d;
            outer_q  <= outer_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sc_mul_lfsr_mc.sv
// tb/tb_sc_mul_lfsr_mc.sv - self-checking bench for sc_mul_lfsr_mc

module tb_sc_mul_lfsr_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 4-bit, 4-lane instance: window 225 cycles
    logic        rst4, start4, mode4, busy4, done4;
    logic [3:0]  seed_a4, seed_b4;
    logic [15:0] a4, b4;
    logic [31:0] result4;

    sc_mul_lfsr_mc #(.WIDTH(4), .NUM_CH(4), .TAPS(4'h9)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .mode(mode4),
        .seed_a(seed_a4), .seed_b(seed_b4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4)
    );

    // 8-bit, 4-lane instance with default parameters: window 65025 cycles
    logic        rst8, start8, mode8, busy8, done8;
    logic [7:0]  seed_a8, seed_b8;
    logic [31:0] a8, b8;
    logic [63:0] result8;
    bit          w8_finished = 1'b0;

    sc_mul_lfsr_mc dut8 (
        .clk(clk), .rst(rst8), .start(start8), .mode(mode8),
        .seed_a(seed_a8), .seed_b(seed_b8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8)
    );

    typedef struct {
        bit          md;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [15:0] av;
        logic [15:0] bv;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] step4(input logic [3:0] s);
        return (s >> 1) ^ (s[0] ? 4'h9 : 4'h0);
    endfunction

    // Reference: A's value at cycle k is its k-th sequence element modulo the
    // period; B has taken k/P steps (exhaustive) or k - k/P steps (rotate).
    function automatic int model_lane(input bit md, input logic [3:0] sa, input logic [3:0] sb,
                                      input int av, input int bv);
        logic [3:0] sq_a [15];
        logic [3:0] sq_b [15];
        int cnt = 0;
        int nb;
        sq_a[0] = (sa == 4'd0) ? 4'd1 : sa;
        sq_b[0] = (sb == 4'd0) ? 4'd1 : sb;
        for (int j = 1; j < 15; j++) begin
            sq_a[j] = step4(sq_a[j-1]);
            sq_b[j] = step4(sq_b[j-1]);
        end
        for (int k = 0; k < 225; k++) begin
            nb = md ? (k / 15) : (k - k / 15);
            if (av > int'(sq_a[k % 15]) && bv > int'(sq_b[nb % 15])) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic [31:0] model_vec(input vec_t v);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = 8'(model_lane(v.md, v.sa, v.sb, int'(v.av[i*4 +: 4]), int'(v.bv[i*4 +: 4])));
        end
        return r;
    endfunction

    // Called on a negedge; returns on the first negedge after the start edge.
    task automatic launch(input vec_t v);
        mode4   = v.md;
        seed_a4 = v.sa;
        seed_b4 = v.sb;
        a4      = v.av;
        b4      = v.bv;
        start4  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4  = 1'b0;
    endtask

    // lat = cycles from start to the done cycle (0 on timeout)
    task automatic wait_done(input int limit, output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        for (int n = 1; n <= limit; n++) begin
            if (n > 1) @(negedge clk);
            if (busy4) busy_n++;
            if (done4) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_result4(input string nm, input logic [31:0] exp);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s lane%0d", nm, i), longint'(result4[i*8 +: 8]), longint'(exp[i*8 +: 8]));
        end
    endtask

    // Long 8-bit exhaustive run in parallel with the 4-bit sequences.
    initial begin
        int lat8;
        rst8 = 1'b1; start8 = 1'b0; mode8 = 1'b0;
        seed_a8 = '0; seed_b8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0;
        check("w8 reset busy", longint'(busy8), 0);
        check("w8 reset result", longint'(result8), 0);
        mode8   = 1'b1;
        seed_a8 = 8'h01;
        seed_b8 = 8'h5A;
        a8      = {8'd128, 8'd64, 8'd255, 8'd1};
        b8      = {8'd64, 8'd128, 8'd255, 8'd200};
        start8  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8  = 1'b0;
        lat8 = 0;
        for (int n = 1; n <= 65100; n++) begin
            if (n > 1) @(negedge clk);
            if (done8) begin
                lat8 = n;
                break;
            end
        end
        check("w8 latency", lat8, 65026);
        check("w8 lane3", longint'(result8[48 +: 16]), 8001);
        check("w8 lane2", longint'(result8[32 +: 16]), 8001);
        check("w8 lane1", longint'(result8[16 +: 16]), 64516);
        check("w8 lane0", longint'(result8[0 +: 16]), 0);
        w8_finished = 1'b1;
    end

    initial begin
        int lat, bcnt, dcnt;
        logic [31:0] first_res;

        rst4 = 1'b1; start4 = 1'b0; mode4 = 1'b0;
        seed_a4 = '0; seed_b4 = '0; a4 = '0; b4 = '0;

        // Exhaustive with zero seeds: lanes (5,4)=12, (0,15)=0, (1,15)=0, (15,15)=196
        vt[0] = '{md: 1'b1, sa: 4'd0, sb: 4'd0,
                  av: {4'd15, 4'd1, 4'd0, 4'd5}, bv: {4'd15, 4'd15, 4'd15, 4'd4},
                  exp: {8'd196, 8'd0, 8'd0, 8'd12}};
        // Rotate with A at 0 or 1 on every lane: always zero
        vt[1] = '{md: 1'b0, sa: 4'd7, sb: 4'd3,
                  av: {4'd1, 4'd0, 4'd1, 4'd0}, bv: {4'd15, 4'd15, 4'd9, 4'd15},
                  exp: 32'd0};
        for (int i = 2; i < 8; i++) begin
            vt[i].md = (i % 2 == 1);
            vt[i].sa = 4'($urandom_range(0, 15));
            vt[i].sb = 4'($urandom_range(0, 15));
            vt[i].av = 16'($urandom);
            vt[i].bv = 16'($urandom);
            vt[i].exp = model_vec(vt[i]);
        end
        // Rotate-mode repeatability: entry 5 replays entry 4
        vt[4].md = 1'b0;
        vt[4].exp = model_vec(vt[4]);
        vt[5] = vt[4];

        repeat (3) @(negedge clk);
        rst4 = 1'b0;
        check("reset busy", longint'(busy4), 0);
        check("reset done", longint'(done4), 0);
        check("reset result", longint'(result4), 0);

        for (int v = 0; v < 6; v++) begin
            launch(vt[v]);
            wait_done(300, lat, bcnt);
            check($sformatf("vec%0d latency", v), lat, 226);
            check($sformatf("vec%0d busy cycles", v), bcnt, 225);
            check_result4($sformatf("vec%0d", v), vt[v].exp);
            @(negedge clk);
            check($sformatf("vec%0d done width", v), longint'(done4), 0);
        end

        // Starts at cycles 10 and 200 of a run are ignored.
        launch(vt[7]);
        dcnt = 0;
        lat  = 0;
        for (int n = 1; n <= 300; n++) begin
            if (n > 1) @(negedge clk);
            start4 = (n == 10 || n == 200);
            if (n == 10) a4 = ~a4;
            if (done4) begin
                dcnt++;
                if (lat == 0) lat = n;
            end
        end
        start4 = 1'b0;
        check("ignore done count", dcnt, 1);
        check("ignore latency", lat, 226);
        check_result4("ignore", vt[7].exp);

        // Reset mid-run aborts with no done and a cleared result.
        launch(vt[6]);
        for (int n = 2; n <= 100; n++) @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        check("abort busy", longint'(busy4), 0);
        check("abort done", longint'(done4), 0);
        check("abort result", longint'(result4), 0);
        dcnt = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done4) dcnt++;
        end
        check("abort no done", dcnt, 0);
        launch(vt[6]);
        wait_done(300, lat, bcnt);
        check("after abort latency", lat, 226);
        check_result4("after abort", vt[6].exp);

        // Back-to-back: start held in the done cycle launches the next run.
        @(negedge clk);
        launch(vt[2]);
        wait_done(300, lat, bcnt);
        check("b2b first latency", lat, 226);
        first_res = vt[2].exp;
        check_result4("b2b first", first_res);
        launch(vt[3]);
        check("b2b busy rise", longint'(busy4), 1);
        check("b2b held result", longint'(result4), longint'(first_res));
        wait_done(300, lat, bcnt);
        check("b2b second latency", lat, 226);
        check_result4("b2b second", vt[3].exp);

        for (int n = 0; n < 70000 && !w8_finished; n++) @(negedge clk);
        check("w8 run finished", longint'(w8_finished), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_mul_lfsr_mc.md
Name: sc_mul_lfsr_mc

Overview:
- Multi-channel, parametrised unipolar stochastic-computing multiplier.
- Per channel, each operand is turned into a bitstream by threshold comparison against one of two shared maximal-length LFSRs. The bitstreams are ANDed and the ones are counted over a fixed window.
- The B-side LFSR either rotates (stalls one cycle per A period) or nests (steps once per A period, giving every A/B pair exactly once). The block adds a start/busy/done handshake and latched results.
- Sits in the SC unit array as the successor of the single-channel rotated-LFSR multiplier.

Parameters:
- WIDTH, 8, operand/LFSR width W (4..16).
- NUM_CH, 4, number of independent multiplier lanes sharing the LFSRs.
- TAPS, 8'hB8, Galois feedback mask of a maximal-length W-bit LFSR; width W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- start  in  1  launch request; sampled only when busy=0.
- mode  in  1  0=rotate, 1=exhaustive; captured at start.
- seed_a  in  WIDTH  A-LFSR seed; 0 is substituted by 1.
- seed_b  in  WIDTH  B-LFSR seed; 0 is substituted by 1.
- a  in  NUM_CH*WIDTH  lane operands A, lane i at [i*W +: W]; captured at start.
- b  in  NUM_CH*WIDTH  lane operands B, same packing; captured at start.
- busy  out  1  high for the duration of the run window.
- done  out  1  one-cycle pulse; result updated in the same cycle.
- result  out  NUM_CH*2*WIDTH  per-lane ones count, lane i at [i*2W +: 2W]; held between runs.

Behaviour:
- Reset (rst=1 at a clk edge) overrides everything: busy=0, done=0, result=0, accumulators=0, LFSRs=1, phase counter=0. Reset mid-run aborts the run; no done pulse and result=0.
- LFSR step (Galois, right shift): next = (s>>1) ^ (s[0] ? TAPS : 0). The period is P = 2^W-1 and the state is never 0.
- Idle (busy=0): a start edge captures a, b, mode and the seeds. It loads LFSR_A=seedA' and LFSR_B=seedB' (after zero substitution), clears the lane accumulators and phase counters, and sets busy=1.
- Start while busy=1 is ignored; captured operands are unaffected.
- Run cycles: the window is N = P*P compare cycles, starting the cycle after start.
  - Each cycle, lane i bit = (A_i > LFSR_A) & (B_i > LFSR_B); the accumulator increments by that bit.
  - LFSR_A steps every cycle.
  - A wrap is a cycle in which LFSR_A's next state equals seedA'.
  - Exhaustive mode: LFSR_B steps only on a wrap cycle.
  - Rotate mode: LFSR_B steps on every cycle except a wrap cycle.
- Phase tracking: inner counter 0..P-1 and outer counter 0..P-1. Run ends after the compare cycle with inner=outer=P-1.
- End of run: on the clock edge ending the last compare cycle, result <= final accumulators (including the last bit) and busy <= 0. done=1 for exactly the following cycle. Latency from start to done = N+1 cycles.
- Back-to-back: start asserted in the done cycle is accepted, since busy=0 then.
- Widths: accumulators and results are 2W bits. The maximum count (P-1)^2 fits, so no saturation is needed.
- Exact results, exhaustive mode, unipolar: lane result = max(A-1,0)*max(B-1,0), independent of seeds. This holds because each LFSR value 1..P occurs once per period and A>v holds for A-1 values.
- Boundary values:
  - A=0 or A=1 gives result 0 in both modes.
  - In rotate mode, result depends on the seeds; it is deterministic and reproducible for equal seeds.

Test Plan:
- W=8, NUM_CH=4, mode=1, seeds 8'h01/8'h5A, a={128,64,255,1}, b={64,128,255,200} -> done at start+65026 cycles; result={8001,8001,64516,0}.
- W=4, TAPS=4'h9, mode=1, a=5, b=4, seed_a=0, seed_b=0 (substituted by 1) -> done exactly 226 cycles after start; result=12; busy high 225 cycles.
- Mode=0, a=0, b=255 -> result 0. Repeat with identical seeds and a=200, b=150 -> bit-identical result on both runs.
- Start pulsed again at cycles 10 and 1000 of a run with different a -> ignored; result equals the single-run value; exactly one done pulse.
- rst asserted at cycle 500 of a run -> next cycle busy=0, result=0, no done. A fresh start after reset produces the correct full-run result.
- Start asserted in the done cycle -> second run accepted; busy rises the next cycle; result holds the first value until the second done.
